// File: rtl/bus_slave_ram_pkg.sv
// -----------------------------------------------------------------------------
// bus_slave_ram_pkg
//   Shared CPU-bus definitions used by bus slaves:
//     - READ / WRITE       : encoding of the s_rw strobe
//     - ENABLE_ / DISABLE_ : levels of the active-low bus strobes
//     - WORD_DATA_W        : bus word width
//     - BUS_SLAVE_STATE_W and bus_slave_state_e : slave handshake state set,
//       intended for reuse by future slaves on the same bus
//     - WAIT_CNT_W         : width of the wait-state counter (0..15 waits)
// -----------------------------------------------------------------------------
package bus_slave_ram_pkg;

    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam int WORD_DATA_W = 32;

    localparam int BUS_SLAVE_STATE_W = 2;

    typedef enum logic [BUS_SLAVE_STATE_W-1:0] {
        BUS_SLAVE_IDLE = 2'd0,
        BUS_SLAVE_WAIT = 2'd1,
        BUS_SLAVE_ACK  = 2'd2
    } bus_slave_state_e;

    localparam int WAIT_CNT_W = 4;

endpackage : bus_slave_ram_pkg

// File: rtl/bus_slave_ram_array.sv
// -----------------------------------------------------------------------------
// bus_slave_ram_array
//   Single-port synchronous RAM with registered read. Kept as its own module so
//   it can be swapped for a vendor memory macro without touching the bus FSM.
//
//   Ports:
//     clk       in  clock, all activity on rising edge
//     we_i      in  write enable: mem[addr_i] <= wdata_i
//     re_i      in  read enable:  rdata_o <= mem[addr_i]
//     addr_i    in  word address
//     wdata_i   in  write data
//     rdata_o   out registered read data (holds between reads)
// -----------------------------------------------------------------------------
module bus_slave_ram_array #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // NOTE: the storage array and read register have no reset; clearing a RAM
    // would prevent mapping it onto block memory, and contents must survive reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : bus_slave_ram_array

// File: rtl/bus_slave_ram.sv
// -----------------------------------------------------------------------------
// bus_slave_ram
//   Word-addressed scratch RAM responding on the shared CPU bus. An access is
//   accepted in IDLE when s_cs_ and s_as_ are both low; address, direction and
//   write data are latched, WAIT_CYCLES wait states follow, then s_rdy_ pulses
//   low for one cycle. s_rd_data is zero except during the acknowledge of a
//   read, so slave outputs can be OR-muxed on the bus.
//
//   Ports:
//     clk        in  clock, all logic on rising edge
//     reset      in  synchronous reset, active-low
//     s_cs_      in  chip select from the address decoder, active-low
//     s_as_      in  address strobe from the granted master, active-low
//     s_rw       in  READ (1) / WRITE (0)
//     s_addr     in  word address
//     s_wr_data  in  write data
//     s_rd_data  out read data, valid only while s_rdy_ is low, else zero
//     s_rdy_     out acknowledge, active-low one-cycle pulse
// -----------------------------------------------------------------------------
module bus_slave_ram
    import bus_slave_ram_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = WORD_DATA_W,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_cs_,
    input  logic              s_as_,
    input  logic              s_rw,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [DATA_W-1:0] s_wr_data,
    output logic [DATA_W-1:0] s_rd_data,
    output logic              s_rdy_
);

    localparam logic [WAIT_CNT_W-1:0] CNT_LOAD = WAIT_CNT_W'(WAIT_CYCLES);

    bus_slave_state_e        state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]       addr_q;
    logic                    rw_q;
    logic [DATA_W-1:0]       wdata_q;

    logic                    accept;
    logic                    enter_ack;

    logic [ADDR_W-1:0]       acc_addr;
    logic                    acc_rw;
    logic [DATA_W-1:0]       acc_wdata;
    logic                    ram_we;
    logic                    ram_re;
    logic [DATA_W-1:0]       ram_rdata;

    // ---------------------------------------------------------------- state
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= BUS_SLAVE_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Access attributes are only meaningful after an accept, so no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= s_addr;
            rw_q    <= s_rw;
            wdata_q <= s_wr_data;
        end
    end

    // ---------------------------------------------------------- next state
    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        enter_ack = 1'b0;

        unique case (state_q)
            BUS_SLAVE_IDLE: begin
                if (s_cs_ == ENABLE_ && s_as_ == ENABLE_) begin
                    accept = 1'b1;
                    cnt_d  = CNT_LOAD;
                    if (WAIT_CYCLES == 0) begin
                        state_d   = BUS_SLAVE_ACK;
                        enter_ack = 1'b1;
                    end else begin
                        state_d = BUS_SLAVE_WAIT;
                    end
                end
            end

            // Bus inputs are ignored here; the latched access completes even
            // if the master withdraws its strobe.
            BUS_SLAVE_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == WAIT_CNT_W'(1)) begin
                    state_d   = BUS_SLAVE_ACK;
                    enter_ack = 1'b1;
                end
            end

            BUS_SLAVE_ACK: begin
                state_d = BUS_SLAVE_IDLE;
            end

            default: begin
                state_d = BUS_SLAVE_IDLE;
            end
        endcase
    end

    // --------------------------------------------------------------- memory
    // With zero wait states the RAM operation happens on the accepting edge
    // itself, before the latches are loaded, so take the live bus values then.
    assign acc_addr  = accept ? s_addr    : addr_q;
    assign acc_rw    = accept ? s_rw      : rw_q;
    assign acc_wdata = accept ? s_wr_data : wdata_q;

    // Reset on the committing edge drops the write.
    assign ram_we = reset && enter_ack && (acc_rw == WRITE);
    assign ram_re = reset && enter_ack && (acc_rw == READ);

    bus_slave_ram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk     (clk),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (acc_addr),
        .wdata_i (acc_wdata),
        .rdata_o (ram_rdata)
    );

    // -------------------------------------------------------------- outputs
    assign s_rdy_    = (state_q == BUS_SLAVE_ACK) ? ENABLE_ : DISABLE_;
    assign s_rd_data = (state_q == BUS_SLAVE_ACK && rw_q == READ) ? ram_rdata : '0;

endmodule : bus_slave_ram

// File: tb/tb_bus_slave_ram.sv
// -----------------------------------------------------------------------------
// tb_bus_slave_ram
//   Two instances: u_dut1 with one wait state, u_dut0 with none. Every access
//   pushes its expected read data and acknowledge cycle to a per-instance
//   queue; a negedge monitor pops on each s_rdy_ pulse and compares, and checks
//   that s_rd_data is zero whenever s_rdy_ is high.
// -----------------------------------------------------------------------------
module tb_bus_slave_ram;
    import bus_slave_ram_pkg::*;

    typedef struct {
        logic [31:0] data;
        int          cyc;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;

    logic        cs1_, as1_, rw1;
    logic [9:0]  addr1;
    logic [31:0] wd1, rd1;
    logic        rdy1_;

    logic        cs0_, as0_, rw0;
    logic [9:0]  addr0;
    logic [31:0] wd0, rd0;
    logic        rdy0_;

    exp_t q1[$];
    exp_t q0[$];

    int   cyc    = 0;
    int   total  = 0;
    int   bad    = 0;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bus_slave_ram #(.ADDR_W(10), .DATA_W(32), .WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .reset(reset), .s_cs_(cs1_), .s_as_(as1_), .s_rw(rw1),
        .s_addr(addr1), .s_wr_data(wd1), .s_rd_data(rd1), .s_rdy_(rdy1_)
    );

    bus_slave_ram #(.ADDR_W(10), .DATA_W(32), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset), .s_cs_(cs0_), .s_as_(as0_), .s_rw(rw0),
        .s_addr(addr0), .s_wr_data(wd0), .s_rd_data(rd0), .s_rdy_(rdy0_)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard monitor, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (rdy1_ == 1'b0) begin
                if (q1.size() == 0) check("dut1_unexpected_ack", 32'd1, 32'd0);
                else begin
                    e = q1.pop_front();
                    check({e.tag, "_data"}, rd1, e.data);
                    check({e.tag, "_cyc"}, 32'(cyc), 32'(e.cyc));
                end
            end else begin
                check("dut1_idle_rd_zero", rd1, 32'd0);
            end
            if (rdy0_ == 1'b0) begin
                if (q0.size() == 0) check("dut0_unexpected_ack", 32'd1, 32'd0);
                else begin
                    e = q0.pop_front();
                    check({e.tag, "_data"}, rd0, e.data);
                    check({e.tag, "_cyc"}, 32'(cyc), 32'(e.cyc));
                end
            end else begin
                check("dut0_idle_rd_zero", rd0, 32'd0);
            end
        end
    end

    task automatic drive(input int sel, input logic cs_, input logic as_, input logic rw,
                         input logic [9:0] addr, input logic [31:0] wd);
        if (sel == 1) begin
            cs1_ = cs_; as1_ = as_; rw1 = rw; addr1 = addr; wd1 = wd;
        end else begin
            cs0_ = cs_; as0_ = as_; rw0 = rw; addr0 = addr; wd0 = wd;
        end
    endtask

    task automatic push(input int sel, input logic [31:0] d, input int c, input string tag);
        exp_t e;
        e.data = d; e.cyc = c; e.tag = tag;
        if (sel == 1) q1.push_back(e); else q0.push_back(e);
    endtask

    task automatic wait_drain(input int sel, input string tag);
        int left;
        left = (sel == 1) ? q1.size() : q0.size();
        for (int i = 0; i < 20 && left != 0; i++) begin
            @(negedge clk);
            left = (sel == 1) ? q1.size() : q0.size();
        end
        check({tag, "_ack_timeout"}, 32'(left), 32'd0);
    endtask

    // One access with strobes held for a single cycle; during any wait state
    // the bus is scrambled to prove only the latched values are used.
    // Acknowledge is expected WAIT_CYCLES edges after the accepting edge.
    task automatic access(input int sel, input logic rw, input logic [9:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_d, input string tag);
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, rw, addr, wd);
        push(sel, exp_d, cyc + 1 + ((sel == 1) ? 1 : 0), tag);
        @(negedge clk);
        drive(sel, 1'b1, 1'b1, ~rw, ~addr, ~wd);
        wait_drain(sel, tag);
    endtask

    initial begin
        logic [9:0]  ra;
        logic [31:0] rd;
        int          c;

        reset = 1'b0;
        drive(1, 1'b1, 1'b1, READ, '0, '0);
        drive(0, 1'b1, 1'b1, READ, '0, '0);
        repeat (3) @(negedge clk);
        reset  = 1'b1;
        mon_en = 1'b1;

        // Idle after reset: no acknowledge, read data zero.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_rdy1", {31'd0, rdy1_}, 32'd1);
            check("idle_rdy0", {31'd0, rdy0_}, 32'd1);
        end

        // One wait state: write then read back.
        access(1, WRITE, 10'h005, 32'h0000_0099, 32'h0, "w1_wr5");
        access(1, READ,  10'h005, 32'h0,         32'h0000_0099, "w1_rd5");

        // Strobe withdrawn during WAIT still completes the write.
        access(1, WRITE, 10'h3FF, 32'hDEAD_BEEF, 32'h0, "w1_wr3ff");
        access(1, READ,  10'h3FF, 32'h0,         32'hDEAD_BEEF, "w1_rd3ff");

        // Reset during WAIT aborts the write to 0x010.
        access(1, WRITE, 10'h010, 32'h0000_1234, 32'h0, "w1_pre010");
        @(negedge clk);
        drive(1, 1'b0, 1'b0, WRITE, 10'h010, 32'hAAAA_5555);
        @(negedge clk);
        drive(1, 1'b1, 1'b1, READ, 10'h000, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("rst_abort_rdy", {31'd0, rdy1_}, 32'd1);
        @(negedge clk);
        check("rst_abort_rdy_late", {31'd0, rdy1_}, 32'd1);
        access(1, READ, 10'h010, 32'h0, 32'h0000_1234, "w1_rd010");

        // Chip select high: another slave's access, must be ignored.
        @(negedge clk);
        drive(1, 1'b1, 1'b0, WRITE, 10'h005, 32'hFFFF_FFFF);
        repeat (3) @(negedge clk);
        check("cs_off_rdy", {31'd0, rdy1_}, 32'd1);
        drive(1, 1'b1, 1'b1, READ, 10'h000, 32'h0);
        access(1, READ, 10'h005, 32'h0, 32'h0000_0099, "w1_rd5_after_cs");

        // Zero wait states: preload, then back-to-back reads with s_as_ held.
        access(0, WRITE, 10'h001, 32'h0000_0011, 32'h0, "w0_wr1");
        access(0, WRITE, 10'h002, 32'h0000_0022, 32'h0, "w0_wr2");
        @(negedge clk);
        c = cyc;
        drive(0, 1'b0, 1'b0, READ, 10'h001, 32'h0);
        push(0, 32'h0000_0011, c + 1, "w0_b2b_rd1");
        push(0, 32'h0000_0022, c + 3, "w0_b2b_rd2");
        @(negedge clk);
        drive(0, 1'b0, 1'b0, READ, 10'h002, 32'h0);
        @(negedge clk);
        check("b2b_gap_rdy", {31'd0, rdy0_}, 32'd1);
        @(negedge clk);
        drive(0, 1'b1, 1'b1, READ, 10'h000, 32'h0);
        wait_drain(0, "w0_b2b");

        // A few random read-after-write pairs on the zero-wait instance.
        for (int i = 0; i < 4; i++) begin
            ra = 10'($urandom_range(16, 1000));
            rd = $urandom;
            access(0, WRITE, ra, rd, 32'h0, "w0_rnd_wr");
            access(0, READ,  ra, 32'h0, rd, "w0_rnd_rd");
        end

        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_bus_slave_ram

// File: doc/bus_slave_ram.md
Name: bus_slave_ram

Overview:
- Word-addressed scratch RAM that acts as the responder on the shared CPU bus.
- It answers the master-side handshake driven by the IF/MEM stages: chip-select plus address strobe in, ready strobe out.
- Wait states are programmable so the bench and SoC can model slow memory.
- Sits behind the bus address decoder; drives zero on read data whenever not acknowledging, so the bus can OR-mux slave outputs.

Parameters:
- ADDR_W, 10, word-address width; depth = 2**ADDR_W words.
- DATA_W, 32, word width; matches WORD_DATA_W.
- WAIT_CYCLES, 1, wait states inserted before acknowledge; legal range 0..15.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous active-low reset.
- s_cs_  in  1  chip select from the bus decoder, active-low.
- s_as_  in  1  address strobe from the granted master, active-low.
- s_rw  in  1  READ (1) / WRITE (0), per the codebase READ/WRITE constants.
- s_addr  in  ADDR_W  word address.
- s_wr_data  in  DATA_W  write data.
- s_rd_data  out  DATA_W  read data; valid only while s_rdy_ is low, zero otherwise.
- s_rdy_  out  1  ready/acknowledge, active-low, one-cycle pulse.

Behaviour:
- Reset (reset low at a clk edge): state = IDLE, s_rdy_ = 1, s_rd_data = 0, wait counter = 0. RAM contents are not cleared.
- Reset mid-access aborts the access with no acknowledge. A pending write is dropped if it has not yet committed.
- FSM states: IDLE, WAIT, ACK.
- IDLE:
  - Access is accepted when s_cs_ = 0 and s_as_ = 0 at a clk edge.
  - On acceptance, latch addr, rw and wr_data; load counter = WAIT_CYCLES.
  - Go to WAIT if WAIT_CYCLES > 0, else go to ACK.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1 and is decremented, go to ACK.
  - Bus inputs are ignored in WAIT; the latched values govern the access.
- Entering ACK:
  - Write: mem[latched addr] <= latched wr_data on the transition edge.
  - Read: s_rd_data <= mem[latched addr] on the same edge.
- ACK:
  - s_rdy_ = 0 for exactly one cycle, then go to IDLE.
  - s_rd_data returns to 0 on leaving ACK.
  - For a write, s_rd_data stays 0 even in ACK.
- Latency: s_rdy_ goes low WAIT_CYCLES+1 cycles after the accepting edge. With WAIT_CYCLES = 1, that is the 2nd cycle after acceptance.
- Back-to-back: a new access can be accepted in the IDLE cycle after ACK, giving a one-cycle turnaround. If the master still holds s_as_ low in that IDLE cycle, it is treated as a new access.
- Strobe withdrawn mid-access (s_as_ or s_cs_ high during WAIT): the access still completes and s_rdy_ still pulses. Writes commit.
- Read-after-write to the same address on consecutive accesses returns the new data.
- Address wrap: the address is exactly ADDR_W bits. No range check; the decoder guarantees selection.
- Signals s_rw and s_wr_data are sampled only at the accepting edge.

Decomposition:
- Shared bus header holds: READ/WRITE, ENABLE_/DISABLE_, and WORD_DATA_W.
- Also in the shared header: a new BUS_SLAVE_STATE_W/`BUS_SLAVE_IDLE/WAIT/ACK` state-encoding set, reused by future slaves.
- One sub-module: bus_slave_ram_array. It is a single-port synchronous RAM (write enable, address, write data, registered read), so it can later be swapped for a vendor macro.
- The FSM, counter and output gating stay in bus_slave_ram.

Test Plan:
- Reset then idle, s_as_ = 1: s_rdy_ stays 1 and s_rd_data = 0 for 10 cycles.
- WAIT_CYCLES = 1:
  - Write 0x0000_0099 to addr 0x005 → s_rdy_ low exactly on the 2nd cycle after acceptance, for 1 cycle.
  - Then read addr 0x005 → s_rd_data = 0x0000_0099 only during the s_rdy_ low cycle.
- WAIT_CYCLES = 0:
  - Back-to-back reads of 0x001 then 0x002 (preloaded 0x11, 0x22), with s_as_ held low → two rdy_ pulses separated by one IDLE cycle, data 0x11 then 0x22.
- Strobe withdrawn: start a write of 0xDEAD_BEEF to 0x3FF, drop s_as_ during WAIT → s_rdy_ still pulses; a later read of 0x3FF returns 0xDEAD_BEEF.
- Reset asserted low during WAIT of a write to 0x010 (old value 0x1234) → no s_rdy_ pulse, state IDLE; a subsequent read returns 0x1234.
- s_cs_ = 1 with s_as_ = 0 (another slave's address) → no acknowledge, s_rd_data stays 0, RAM unchanged.
